l1_cache: RTL and testbench
===========================

# l1_cache

Direct-mapped, write-back, write-allocate L1 data cache between the CPU load/store port and the L2 cache. Serves one outstanding CPU request at a time, answers hits in two cycles, and on a miss optionally evicts a dirty line to L2, then fills the line from L2. Lines are one word wide, and its L2-side signals connect directly to the L2 cache's L1 port.

## Interface
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 32, byte address width.
- NUM_LINES, 64, number of lines; must be a power of two.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_addr  in  ADDR_WIDTH  byte address; bits [1:0] are ignored.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_read  in  1  load request.
- cpu_write  in  1  store request.
- cpu_rdata  out  DATA_WIDTH  load data; valid while cpu_ready is high.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_hit  out  1  high with cpu_ready when the first tag check hit.
- l2_addr  out  ADDR_WIDTH  line address; bits [1:0] are always 0.
- l2_wdata  out  DATA_WIDTH  eviction data.
- l2_read  out  1  fill request.
- l2_write  out  1  write-back request.
- l2_rdata  in  DATA_WIDTH  fill data; valid with l2_ready.
- l2_ready  in  1  L2 completion pulse.
- l2_hit  in  1  informational only; ignored.

## Operation
- Address split: offset = [1:0]; index = [IW+1:2] with IW = $clog2(NUM_LINES); tag = [ADDR_WIDTH-1:IW+2].
- Per-line storage: valid bit, dirty bit, tag and data.
- States and transitions:
  - IDLE: if cpu_read or cpu_write, latch addr, wdata and op, then go to TAG_CHECK. If both are set, the request is a write.
  - TAG_CHECK, on hit (valid and tag match): a read captures data into cpu_rdata; a write stores wdata and sets dirty. Go to RESPOND.
  - TAG_CHECK, on miss: set the latched miss flag. Go to WRITE_BACK if the line is valid and dirty, otherwise to ALLOCATE.
  - WRITE_BACK: l2_write=1, l2_addr = {old tag, index, 2'b00}, l2_wdata = old data. On l2_ready, clear dirty and go to ALLOCATE.
  - ALLOCATE: l2_read=1, l2_addr = {latched tag, index, 2'b00}. On l2_ready, write l2_rdata, the tag, valid=1 and dirty=0, then return to TAG_CHECK. The re-check always hits.
  - RESPOND: cpu_ready=1 and cpu_hit = !miss flag. Go to IDLE.
- Latched request registers isolate the cache from CPU bus changes during a request.
- l2_read and l2_write are never high together.
- l2_addr and l2_wdata are held stable while a request is pending.
- The data array is not reset. Valid and dirty bits are cleared on reset.

## Timing
- Reset values: all outputs are 0; state = IDLE; all valid and dirty bits are 0; miss flag is 0.
- Reset asserted mid-operation aborts immediately: L2 strobes drop asynchronously and the pending CPU request is dropped without cpu_ready.
- Hit latency: request sampled at edge 0 (IDLE), TAG_CHECK in cycle 1, cpu_ready high in cycle 2.
- Clean-miss latency: 2 cycles + L2 latency + 2 cycles.
- Dirty miss adds one extra L2 round trip.
- CPU handshake:
  - The request is sampled only in IDLE.
  - The CPU drops or changes its request after the clock edge at which it sees cpu_ready.
  - The cycle after RESPOND is IDLE, so back-to-back requests are accepted.
- L2 handshake:
  - Strobes are Moore outputs: high for every cycle in WRITE_BACK or ALLOCATE.
  - Strobes fall at the edge that consumes l2_ready.
  - WRITE_BACK to ALLOCATE swaps l2_write to l2_read at a single edge.
  - l2_ready outside WRITE_BACK or ALLOCATE is ignored.

## Configuration
- Macro: L1_CACHE_STATS_EN.
- When defined, the block adds three outputs, each 32-bit with wrap-around at 2^32 and reset to 0:
  - hit_count: increments once per request in RESPOND when cpu_hit=1.
  - miss_count: increments once per request in RESPOND when cpu_hit=0.
  - wb_count: increments per accepted write-back l2_ready.
- When undefined, these ports and counters do not exist, and functional behaviour is identical.

## Structure
- Package l1_cache_pkg holds:
  - the state enum (IDLE, TAG_CHECK, WRITE_BACK, ALLOCATE, RESPOND);
  - the offset-width constant 2;
  - functions computing index and tag width from NUM_LINES and ADDR_WIDTH.
- Sub-module l1_tag_array holds the valid, dirty and tag arrays:
  - asynchronous read and synchronous write;
  - async clear of valid and dirty;
  - a combinational hit output.
- The data array and FSM stay in l1_cache.

## Test plan
- Cold read 0x0000_0100 with L2 returning 0xDEADBEEF after 3 cycles: one l2_read at l2_addr 0x100; cpu_ready with cpu_hit=0 and cpu_rdata=0xDEADBEEF.
- Repeat the read of 0x100: cpu_ready in cycle 2 with cpu_hit=1 and 0xDEADBEEF; no L2 activity.
- Write 0x12345678 to 0x100 (hit), then read 0x200 (same index 0, tag 2):
  - l2_write at 0x100 with l2_wdata 0x12345678;
  - then l2_read at 0x200;
  - then cpu_ready with cpu_hit=0.
- cpu_read and cpu_write both high at 0x100 with wdata 0xA5A5A5A5: treated as a write; a following read returns 0xA5A5A5A5.
- rst_n pulsed low during ALLOCATE: l2_read falls immediately; no cpu_ready; the next read of the same address misses.
- With L1_CACHE_STATS_EN, for the sequence above before the reset: hit_count=2, miss_count=2, wb_count=1.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped L1 data cache.
package l1_cache_pkg;

    localparam int unsigned OffsetWidth = 2;

    typedef enum logic [2:0] {
        StIdle,
        StTagCheck,
        StWriteBack,
        StAllocate,
        StRespond
    } l1_state_e;

    function automatic int unsigned idx_width(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_width,
                                              input int unsigned num_lines);
        return addr_width - $clog2(num_lines) - OffsetWidth;
    endfunction

endpackage

// File: rtl/l1_tag_array.sv
// Valid/dirty/tag storage for the L1 cache: asynchronous read, synchronous write,
// valid and dirty cleared by reset, combinational hit against the requested tag.
module l1_tag_array #(
    parameter int unsigned NUM_LINES = 64,
    parameter int unsigned IDX_WIDTH = 6,
    parameter int unsigned TAG_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_WIDTH-1:0] idx_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic                 fill_i,
    input  logic                 set_dirty_i,
    input  logic                 clr_dirty_i,
    output logic                 valid_o,
    output logic                 dirty_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 hit_o
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_WIDTH-1:0] tag_q [NUM_LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (set_dirty_i) begin
            dirty_q[idx_i] <= 1'b1;
        end else if (clr_dirty_i) begin
            dirty_q[idx_i] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[idx_i] <= tag_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign hit_o   = valid_o && (tag_o == tag_i);

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with one-word lines.
// Optional statistics counters are enabled by defining L1_CACHE_STATS_EN.
module l1_cache
    import l1_cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_LINES  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    input  logic                  cpu_read_i,
    input  logic                  cpu_write_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_ready_o,
    output logic                  cpu_hit_o,
    output logic [ADDR_WIDTH-1:0] l2_addr_o,
    output logic [DATA_WIDTH-1:0] l2_wdata_o,
    output logic                  l2_read_o,
    output logic                  l2_write_o,
    input  logic [DATA_WIDTH-1:0] l2_rdata_i,
    input  logic                  l2_ready_i,
`ifdef L1_CACHE_STATS_EN
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o,
    output logic [31:0]           wb_count_o,
`endif
    input  logic                  l2_hit_i
);

    localparam int unsigned IW = idx_width(NUM_LINES);
    localparam int unsigned TW = tag_width(ADDR_WIDTH, NUM_LINES);

    l1_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  is_write_q;
    logic                  miss_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES];

    logic [IW-1:0] idx;
    logic [TW-1:0] req_tag;
    logic [TW-1:0] old_tag;
    logic          line_valid, line_dirty, tag_hit;

    logic                  fill, set_dirty, clr_dirty, miss_set, rdata_we, data_we;
    logic [DATA_WIDTH-1:0] data_wval;

    logic unused_inputs;
    assign unused_inputs = ^{l2_hit_i, addr_q[OffsetWidth-1:0]};

    assign idx     = addr_q[IW+OffsetWidth-1:OffsetWidth];
    assign req_tag = addr_q[ADDR_WIDTH-1:IW+OffsetWidth];

    l1_tag_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_WIDTH (IW),
        .TAG_WIDTH (TW)
    ) u_tag_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_i       (idx),
        .tag_i       (req_tag),
        .fill_i      (fill),
        .set_dirty_i (set_dirty),
        .clr_dirty_i (clr_dirty),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .tag_o       (old_tag),
        .hit_o       (tag_hit)
    );

    always_comb begin
        state_d   = state_q;
        fill      = 1'b0;
        set_dirty = 1'b0;
        clr_dirty = 1'b0;
        miss_set  = 1'b0;
        rdata_we  = 1'b0;
        data_we   = 1'b0;
        data_wval = l2_rdata_i;
        unique case (state_q)
            StIdle: begin
                if (cpu_read_i || cpu_write_i) begin
                    state_d = StTagCheck;
                end
            end
            StTagCheck: begin
                if (tag_hit) begin
                    if (is_write_q) begin
                        data_we   = 1'b1;
                        data_wval = wdata_q;
                        set_dirty = 1'b1;
                    end else begin
                        rdata_we = 1'b1;
                    end
                    state_d = StRespond;
                end else begin
                    miss_set = 1'b1;
                    state_d  = (line_valid && line_dirty) ? StWriteBack : StAllocate;
                end
            end
            StWriteBack: begin
                if (l2_ready_i) begin
                    clr_dirty = 1'b1;
                    state_d   = StAllocate;
                end
            end
            StAllocate: begin
                if (l2_ready_i) begin
                    fill    = 1'b1;
                    data_we = 1'b1;
                    state_d = StTagCheck;
                end
            end
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Request is latched in IDLE so CPU bus changes cannot disturb an in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            miss_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && (cpu_read_i || cpu_write_i)) begin
                addr_q     <= cpu_addr_i;
                wdata_q    <= cpu_wdata_i;
                is_write_q <= cpu_write_i;
                miss_q     <= 1'b0;
            end
            if (miss_set) begin
                miss_q <= 1'b1;
            end
            if (rdata_we) begin
                rdata_q <= data_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[idx] <= data_wval;
        end
    end

    always_comb begin
        l2_read_o  = (state_q == StAllocate);
        l2_write_o = (state_q == StWriteBack);
        l2_addr_o  = '0;
        l2_wdata_o = '0;
        if (state_q == StWriteBack) begin
            l2_addr_o  = {old_tag, idx, {OffsetWidth{1'b0}}};
            l2_wdata_o = data_q[idx];
        end else if (state_q == StAllocate) begin
            l2_addr_o = {req_tag, idx, {OffsetWidth{1'b0}}};
        end
    end

    assign cpu_ready_o = (state_q == StRespond);
    assign cpu_hit_o   = cpu_ready_o && !miss_q;
    assign cpu_rdata_o = rdata_q;

`ifdef L1_CACHE_STATS_EN
    logic [31:0] hit_count_q, miss_count_q, wb_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            if (state_q == StRespond && !miss_q) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (state_q == StRespond && miss_q) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
            if (state_q == StWriteBack && l2_ready_i) begin
                wb_count_q <= wb_count_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
    assign wb_count_o   = wb_count_q;
`endif

endmodule

// File: tb/tb_l1_cache.sv
// Directed self-checking bench for l1_cache with a fixed-latency L2 memory model.
// Covers hits, clean/dirty misses, read+write collision and mid-fill reset.
module tb_l1_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_hit;
    logic [31:0] l2_addr;
    logic [31:0] l2_wdata;
    logic        l2_read;
    logic        l2_write;
    logic [31:0] l2_rdata = '0;
    logic        l2_ready = 1'b0;
`ifdef L1_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int proto_err = 0;

    logic [31:0] mem [logic [31:0]];
    logic        lg_wr    [$];
    logic [31:0] lg_addr  [$];
    logic [31:0] lg_wdata [$];
    int          l2_cnt = 0;
    logic [31:0] hold_addr = '0;

    always #5 clk = ~clk;

    l1_cache dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_read_i   (cpu_read),
        .cpu_write_i  (cpu_write),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_ready_o  (cpu_ready),
        .cpu_hit_o    (cpu_hit),
        .l2_addr_o    (l2_addr),
        .l2_wdata_o   (l2_wdata),
        .l2_read_o    (l2_read),
        .l2_write_o   (l2_write),
        .l2_rdata_i   (l2_rdata),
        .l2_ready_i   (l2_ready),
`ifdef L1_CACHE_STATS_EN
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count),
        .wb_count_o   (wb_count),
`endif
        .l2_hit_i     (1'b0)
    );

    // L2 answers the third cycle a strobe is seen; also polices strobe/address rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            l2_ready = 1'b0;
            l2_cnt   = 0;
        end else begin
            l2_ready = 1'b0;
            if (l2_read && l2_write) proto_err++;
            if (l2_read || l2_write) begin
                if (l2_cnt == 0) hold_addr = l2_addr;
                else if (l2_addr != hold_addr) proto_err++;
                l2_cnt++;
                if (l2_cnt == 3) begin
                    l2_cnt   = 0;
                    l2_ready = 1'b1;
                    lg_wr.push_back(l2_write);
                    lg_addr.push_back(l2_addr);
                    lg_wdata.push_back(l2_wdata);
                    if (l2_write) mem[l2_addr] = l2_wdata;
                    else l2_rdata = mem.exists(l2_addr) ? mem[l2_addr] : 32'h0;
                end
            end else begin
                l2_cnt = 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request, scrambles the bus after acceptance, returns the ready cycle index.
    task automatic cpu_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic hit, output int lat);
        bit seen = 0;
        @(negedge clk);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = 32'hFFFF_FFFC;
        cpu_wdata = 32'h5555_5555;
        lat   = 0;
        rdata = '0;
        hit   = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (cpu_ready) begin
                seen  = 1;
                lat   = n;
                rdata = cpu_rdata;
                hit   = cpu_hit;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        hit;
        int          lat;
        int          base;
        bit          saw;

        mem[32'h100] = 32'hDEAD_BEEF;
        mem[32'h200] = 32'hCAFE_F00D;
        mem[32'h104] = 32'h0BAD_F00D;

        #23;
        check_eq("rst_ready", {31'b0, cpu_ready}, 32'h0);
        check_eq("rst_hit", {31'b0, cpu_hit}, 32'h0);
        check_eq("rst_rdata", cpu_rdata, 32'h0);
        check_eq("rst_l2_strobes", {30'b0, l2_read, l2_write}, 32'h0);
        check_eq("rst_l2_addr", l2_addr, 32'h0);
        check_eq("rst_l2_wdata", l2_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        base = lg_addr.size();
        cpu_req(1'b1, 1'b0, 32'h100, 32'h0, rd, hit, lat);
        check_eq("cold_lat", 32'(lat), 32'd6);
        check_eq("cold_hit", {31'b0, hit}, 32'h0);
        check_eq("cold_data", rd, 32'hDEAD_BEEF);
        check_eq("cold_l2_n", 32'(lg_addr.size() - base), 32'd1);
        if (lg_addr.size() > base) begin
            check_eq("cold_l2_type", {31'b0, lg_wr[base]}, 32'h0);
            check_eq("cold_l2_addr", lg_addr[base], 32'h100);
        end

        base = lg_addr.size();
        cpu_req(1'b1, 1'b0, 32'h100, 32'h0, rd, hit, lat);
        check_eq("rehit_lat", 32'(lat), 32'd2);
        check_eq("rehit_hit", {31'b0, hit}, 32'h1);
        check_eq("rehit_data", rd, 32'hDEAD_BEEF);
        check_eq("rehit_l2_n", 32'(lg_addr.size() - base), 32'd0);

        cpu_req(1'b0, 1'b1, 32'h100, 32'h1234_5678, rd, hit, lat);
        check_eq("wrhit_lat", 32'(lat), 32'd2);
        check_eq("wrhit_hit", {31'b0, hit}, 32'h1);
        check_eq("wrhit_l2_n", 32'(lg_addr.size() - base), 32'd0);

        base = lg_addr.size();
        cpu_req(1'b1, 1'b0, 32'h200, 32'h0, rd, hit, lat);
        check_eq("dirty_lat", 32'(lat), 32'd9);
        check_eq("dirty_hit", {31'b0, hit}, 32'h0);
        check_eq("dirty_data", rd, 32'hCAFE_F00D);
        check_eq("dirty_l2_n", 32'(lg_addr.size() - base), 32'd2);
        if (lg_addr.size() >= base + 2) begin
            check_eq("wb_type", {31'b0, lg_wr[base]}, 32'h1);
            check_eq("wb_addr", lg_addr[base], 32'h100);
            check_eq("wb_data", lg_wdata[base], 32'h1234_5678);
            check_eq("fill_type", {31'b0, lg_wr[base+1]}, 32'h0);
            check_eq("fill_addr", lg_addr[base+1], 32'h200);
        end
`ifdef L1_CACHE_STATS_EN
        check_eq("stat_hits", hit_count, 32'd2);
        check_eq("stat_misses", miss_count, 32'd2);
        check_eq("stat_wbs", wb_count, 32'd1);
`endif

        base = lg_addr.size();
        cpu_req(1'b1, 1'b1, 32'h100, 32'hA5A5_A5A5, rd, hit, lat);
        check_eq("both_lat", 32'(lat), 32'd6);
        check_eq("both_hit", {31'b0, hit}, 32'h0);
        check_eq("both_l2_n", 32'(lg_addr.size() - base), 32'd1);
        cpu_req(1'b1, 1'b0, 32'h100, 32'h0, rd, hit, lat);
        check_eq("both_rd_hit", {31'b0, hit}, 32'h1);
        check_eq("both_rd_data", rd, 32'hA5A5_A5A5);

        @(negedge clk);
        cpu_read = 1'b1;
        cpu_addr = 32'h104;
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        saw = 0;
        for (int n = 0; n < 10 && !saw; n++) begin
            @(negedge clk);
            if (l2_read) saw = 1;
        end
        check_eq("rstmid_fill_seen", {31'b0, saw}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_l2_read", {31'b0, l2_read}, 32'h0);
        check_eq("rstmid_l2_addr", l2_addr, 32'h0);
        saw = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n == 1) rst_n = 1'b1;
            if (cpu_ready) saw = 1;
        end
        check_eq("rstmid_no_ready", {31'b0, saw}, 32'h0);
`ifdef L1_CACHE_STATS_EN
        check_eq("rstmid_stat_hits", hit_count, 32'd0);
`endif
        cpu_req(1'b1, 1'b0, 32'h104, 32'h0, rd, hit, lat);
        check_eq("post_rst_hit", {31'b0, hit}, 32'h0);
        check_eq("post_rst_lat", 32'(lat), 32'd6);
        check_eq("post_rst_data", rd, 32'h0BAD_F00D);
        cpu_req(1'b1, 1'b0, 32'h100, 32'h0, rd, hit, lat);
        check_eq("post_rst_line0_hit", {31'b0, hit}, 32'h0);
        check_eq("post_rst_line0_data", rd, 32'h1234_5678);

        check_eq("l2_protocol", 32'(proto_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
